// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
//   BRAM_ADDR_W / BRAM_DATA_W : geometry of the 512x32 dual-port BRAM port
//   state_e                   : command FSM states
package bram_stream_reader_pkg;
  localparam int BRAM_ADDR_W = 9;
  localparam int BRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;
endpackage

// File: rtl/bram_rd_buf.sv
// Small synchronous FIFO holding {last, data} words returned by the BRAM.
//   clk, rst_n            : clock, async active-low reset
//   push, push_last/data  : write one entry
//   pop                   : drop the head entry
//   head_last, head_data  : head entry (meaningful while count != 0)
//   count                 : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module bram_rd_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_last,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_last,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);
  logic [DEPTH-1:0][DATA_W:0] mem;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign {head_last, head_data} = mem[rd_ptr];
endmodule

// File: rtl/bram_stream_reader.sv
// Reads LEN consecutive BRAM words starting at BASE and streams them out
// on a valid/ready interface. Drives the read side of one BRAM port.
//   CLK, RSTN              : clock, async active-low reset
//   START, BASE, LEN       : command (accepted only while idle)
//   BUSY, DONE             : command in progress / one-cycle completion pulse
//   A, CE, WE, WEM, D, Q   : BRAM port (write pins tied inactive)
//   OUT_VALID/READY/DATA/LAST : output stream
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int BUF_D  = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] A,
  output logic              CE,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST
);
  localparam int CNT_W = $clog2(BUF_D + 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q, issued, accepted;
  logic              inflight, inflight_last, done_q;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    credit_use;
  logic              issue, issue_last, pop, pop_last, start_ok;

  assign start_ok   = (state == IDLE) && START;
  assign pop        = OUT_VALID & OUT_READY;
  assign issue_last = (issued + 1'b1) == len_q;
  assign pop_last   = (accepted + 1'b1) == len_q;

  // Slots committed after this cycle: buffered + in-flight, less the word
  // leaving now. Counting the departing word keeps the stream at one word
  // per cycle with a 2-deep buffer; Q is always captured, never stalled.
  assign credit_use = {1'b0, occ} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign issue      = (state == RUN) && (credit_use < (CNT_W + 1)'(BUF_D));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START && LEN != '0) state_nxt = RUN;
      RUN:     if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && pop_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      accepted      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue & issue_last;
      // Zero-length commands complete without touching the BRAM.
      done_q        <= (start_ok && LEN == '0) || (state == DRAIN && pop && pop_last);
      if (start_ok) begin
        base_q   <= BASE;
        len_q    <= LEN;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue && issued != len_q)  issued   <= issued + 1'b1;
        if (pop && accepted != len_q)  accepted <= accepted + 1'b1;
      end
    end
  end

  bram_rd_buf #(.DATA_W(DATA_W), .DEPTH(BUF_D)) u_buf (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (Q),
    .pop       (pop),
    .head_last (OUT_LAST),
    .head_data (OUT_DATA),
    .count     (occ)
  );

  // Address wraps naturally through the ADDR_W-bit truncation.
  assign A         = base_q + issued[ADDR_W-1:0];
  assign CE        = issue;
  assign WE        = 1'b0;
  assign WEM       = '0;
  assign D         = '0;
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign OUT_VALID = (occ != '0);
endmodule
